module_keypad_scan: RTL
=======================

Name: module_keypad_scan

Overview:
- Scanner/driver side of the 4x4 matrix keypad feeding the multiplier's operand entry path.
- Drives active-low one-hot column strobes, walks columns round-robin and samples the pulled-up row lines.
- Debounces a single pressed key and emits a 4-bit key code with a one-cycle valid pulse.
- Releases are also debounced, so one physical press yields exactly one event.

Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven before the rows are sampled (settle/dwell time), >=2.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required to confirm a press or a release, >=1.
- REPEAT_CYCLES, 25000000: auto-repeat period in cycles; used only when KEYPAD_AUTOREPEAT_EN is defined.

Ports:
- clk_i  input  1  system clock
- rst_n_i  input  1  asynchronous active-low reset
- fil_i  input  4  keypad row lines, active low, asynchronous to clk_i
- col_o  output  4  column drive, active-low one-hot
- dato_codc_o  output  2  index of the column currently driven
- key_code_o  output  4  {row_code[1:0], col_code[1:0]} of the last confirmed key
- key_valid_o  output  1  one-cycle pulse when key_code_o updates
- key_held_o  output  1  high while a confirmed key remains pressed

Behaviour:
- Clock and reset:
  - One clock. rst_n_i is asynchronous assert and synchronous deassert, active low.
- Reset values:
  - col_o=4'b1110, dato_codc_o=0, key_code_o=0, key_valid_o=0, key_held_o=0.
  - State SCAN, all counters 0, synchronizer flops 4'b1111.
- Input synchronizer:
  - fil_i passes through a 2-flop synchronizer; all decisions use the synchronized value fs.
- Row decode (combinational on fs):
  - 1110->0, 1101->1, 1011->2, 0111->3 are "single".
  - 1111 is "idle".
  - Any other pattern is "multi" and is treated as no key (ghost rejection).
- col_o is always ~(4'b0001 << col). dato_codc_o = col.
- FSM states and transitions:
  - SCAN: the dwell counter counts 0..SCAN_DIV-1. On the last count:
    - fs single: latch row/col, clear the debounce counter, go to DEBOUNCE.
    - otherwise: col <= col+1 (3 wraps to 0) and the dwell counter restarts.
  - DEBOUNCE: column is held.
    - Each cycle fs equals the latched pattern: counter increments.
    - Any mismatch: return to SCAN and advance the column.
    - Counter reaches DEBOUNCE_CYCLES-1 with a match: go to PRESSED, set key_code_o={row,col}, pulse key_valid_o for exactly one cycle.
  - PRESSED: key_held_o=1, column held. When fs becomes idle, clear the counter and go to RELEASE.
  - RELEASE: key_held_o stays 1.
    - Each idle cycle increments the counter; any non-idle cycle clears it and the FSM stays in RELEASE.
    - At DEBOUNCE_CYCLES-1 consecutive idle cycles: key_held_o=0, advance the column, go to SCAN.
- Latency: press edge to key_valid_o <= 2 (sync) + 4*SCAN_DIV + DEBOUNCE_CYCLES cycles.
- Boundary conditions:
  - A second key pressed while in PRESSED is ignored; no new event until full release.
  - key_code_o holds its value between events.
  - Column wrap 3->0 has no gap cycle.
  - Reset mid-operation returns to the reset values immediately, even during a key_valid_o pulse.
  - Counters are sized $clog2 of their parameter; no overflow is possible.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined: in PRESSED, a repeat counter counts REPEAT_CYCLES.
  - Each time it expires, key_valid_o pulses again with the unchanged key_code_o and the counter restarts.
  - Entering RELEASE clears the counter.
- Undefined: the repeat counter is absent; exactly one key_valid_o per press.

Decomposition:
- Shared package keypad_pkg:
  - state typedef (SCAN, DEBOUNCE, PRESSED, RELEASE), 2-bit enum.
  - ROW_IDLE=4'b1111 constant.
  - Row-decode function returning {single, code[1:0]}.
- One natural sub-module, module_sync_debounce_cnt: a generic "count N consecutive cycles of condition, clear on break" counter, instantiated for both press and release confirmation.

Test Plan (bench uses SCAN_DIV=4, DEBOUNCE_CYCLES=8, REPEAT_CYCLES=40; keypad model pulls row r low when col_o[c]==0 and key (r,c) is pressed):
- Idle after reset -> col_o cycles 1110,1101,1011,0111,1110 every 4 cycles; key_valid_o stays 0; key_code_o=0.
- Press (row 2, col 1) held for 100 cycles -> exactly one key_valid_o pulse with key_code_o=4'b1001; key_held_o=1 until 8 idle cycles after release.
- Bounce: press (0,3) for 5 cycles, release, repeat 3 times -> no key_valid_o; then hold stable -> one pulse, key_code_o=4'b0011.
- Ghost: keys (1,2) and (3,2) pressed together -> fs=0101 is multi, no event; release (1,2) -> event with key_code_o=4'b1110.
- Assert rst_n_i low during DEBOUNCE for (1,0) -> outputs return to reset values on the same edge; after release of reset, the scan restarts at col 0.
- With KEYPAD_AUTOREPEAT_EN, hold (3,3) for 150 cycles after confirmation -> pulses at confirmation plus every 40 cycles (4 total), key_code_o=4'b1111; without the macro -> 1 pulse.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and row decode for the 4x4 keypad scanner.
// Optional auto-repeat in the top is enabled by defining KEYPAD_AUTOREPEAT_EN.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } kp_state_t;

    localparam logic [3:0] ROW_IDLE = 4'b1111;

    typedef struct packed {
        logic       single;
        logic [1:0] code;
    } row_dec_t;

    // Exactly one row low is a key; several rows low is a ghost and is treated as no key.
    function automatic row_dec_t row_decode(input logic [3:0] rows);
        row_dec_t d;
        d = '{single: 1'b0, code: 2'd0};
        case (rows)
            4'b1110: d = '{single: 1'b1, code: 2'd0};
            4'b1101: d = '{single: 1'b1, code: 2'd1};
            4'b1011: d = '{single: 1'b1, code: 2'd2};
            4'b0111: d = '{single: 1'b1, code: 2'd3};
            default: d = '{single: 1'b0, code: 2'd0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/module_sync_debounce_cnt.sv
// Counts N consecutive cycles of cond_i; any break or clr_i restarts the count.
// done_o is asserted on the N-th consecutive cycle.
module module_sync_debounce_cnt
    import keypad_pkg::*;
#(
    parameter int N = 8
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic cond_i,
    output logic done_o
);

    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic [W-1:0] cnt;

    assign done_o = cond_i && !clr_i && (cnt == W'(N - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            cnt <= '0;
        else if (clr_i || !cond_i || done_o)
            cnt <= '0;
        else
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/module_keypad_scan.sv
// 4x4 matrix keypad scanner: round-robin column drive, debounced press/release, one event per press.
// Define KEYPAD_AUTOREPEAT_EN to re-pulse key_valid_o every REPEAT_CYCLES while a key is held.
module module_keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [3:0] fil_i,
    output logic [3:0] col_o,
    output logic [1:0] dato_codc_o,
    output logic [3:0] key_code_o,
    output logic       key_valid_o,
    output logic       key_held_o
);

    localparam int DW = $clog2(SCAN_DIV);

    kp_state_t     state;
    logic [3:0]    fs_meta, fs;
    logic [1:0]    col, row_lat;
    logic [3:0]    pat_lat;
    logic [DW-1:0] dwell;
    row_dec_t      dec;
    logic          press_done, rel_done, rep_fire;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fs_meta <= ROW_IDLE;
            fs      <= ROW_IDLE;
        end else begin
            fs_meta <= fil_i;
            fs      <= fs_meta;
        end
    end

    assign dec         = row_decode(fs);
    assign col_o       = ~(4'b0001 << col);
    assign dato_codc_o = col;

    module_sync_debounce_cnt #(.N(DEBOUNCE_CYCLES)) u_press_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (state != DEBOUNCE),
        .cond_i  (fs == pat_lat),
        .done_o  (press_done)
    );

    module_sync_debounce_cnt #(.N(DEBOUNCE_CYCLES)) u_release_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (state != RELEASE),
        .cond_i  (fs == ROW_IDLE),
        .done_o  (rel_done)
    );

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    logic [RW-1:0] rep_cnt;

    assign rep_fire = (state == PRESSED) && (fs != ROW_IDLE) && (rep_cnt == RW'(REPEAT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            rep_cnt <= '0;
        else if (state != PRESSED || fs == ROW_IDLE || rep_fire)
            rep_cnt <= '0;
        else
            rep_cnt <= rep_cnt + RW'(1);
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= SCAN;
            col         <= 2'd0;
            dwell       <= '0;
            row_lat     <= 2'd0;
            pat_lat     <= ROW_IDLE;
            key_code_o  <= 4'd0;
            key_valid_o <= 1'b0;
            key_held_o  <= 1'b0;
        end else begin
            key_valid_o <= 1'b0;
            case (state)
                SCAN: begin
                    if (dwell == DW'(SCAN_DIV - 1)) begin
                        dwell <= '0;
                        if (dec.single) begin
                            row_lat <= dec.code;
                            pat_lat <= fs;
                            state   <= DEBOUNCE;
                        end else begin
                            col <= col + 2'd1;
                        end
                    end else begin
                        dwell <= dwell + DW'(1);
                    end
                end
                DEBOUNCE: begin
                    if (fs != pat_lat) begin
                        state <= SCAN;
                        col   <= col + 2'd1;
                    end else if (press_done) begin
                        state       <= PRESSED;
                        key_code_o  <= {row_lat, col};
                        key_valid_o <= 1'b1;
                        key_held_o  <= 1'b1;
                    end
                end
                PRESSED: begin
                    // Extra keys only change the pattern to another non-idle value; wait for full release.
                    if (fs == ROW_IDLE)
                        state <= RELEASE;
                    else if (rep_fire)
                        key_valid_o <= 1'b1;
                end
                RELEASE: begin
                    if (rel_done) begin
                        state      <= SCAN;
                        key_held_o <= 1'b0;
                        col        <= col + 2'd1;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule
